// File: rtl/poliriscv_run_ctrl.sv
// Run-control sequencer gating poliriscv_sc via core_en: RUN/STEP/HALT commands, PC breakpoint and self-loop halts.
// Commands are always accepted (cmd_ready=1); define POLIRISCV_RUNCTRL_PERF_EN to add the instret counter.
module poliriscv_run_ctrl #(
  parameter int PCW   = 32,
  parameter int STEPW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [STEPW-1:0] cmd_arg,
  input  logic             bkpt_en,
  input  logic [PCW-1:0]   bkpt_addr,
  input  logic [PCW-1:0]   core_pc,
  output logic             core_en,
  output logic [1:0]       state,
  output logic [2:0]       halt_cause,
  output logic             done
`ifdef POLIRISCV_RUNCTRL_PERF_EN
  ,
  output logic [31:0]      instret
`endif
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;

  localparam logic [2:0] CAUSE_NONE      = 3'd0;
  localparam logic [2:0] CAUSE_CMD       = 3'd1;
  localparam logic [2:0] CAUSE_STEP_DONE = 3'd2;
  localparam logic [2:0] CAUSE_BKPT      = 3'd3;
  localparam logic [2:0] CAUSE_SELFLOOP  = 3'd4;

  localparam logic [STEPW-1:0] CNT_ONE  = STEPW'(1);
  localparam logic [STEPW-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic             done_q, done_d;
  logic [STEPW-1:0] cnt_q, cnt_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic             v_q, v_d;
  logic             skip_q, skip_d;

  logic             active;
  logic             halt_now;
  logic [2:0]       halt_now_cause;

  assign cmd_ready  = 1'b1;
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign done       = done_q;
  assign active     = (state_q == ST_RUN) || (state_q == ST_STEP);

  // Priority: explicit HALT, then self-loop, then breakpoint (masked on the resume cycle).
  always_comb begin
    halt_now       = 1'b0;
    halt_now_cause = CAUSE_NONE;
    if (active) begin
      if (cmd_valid && (cmd_op == OP_HALT)) begin
        halt_now       = 1'b1;
        halt_now_cause = CAUSE_CMD;
      end else if (v_q && (core_pc == pc_q)) begin
        halt_now       = 1'b1;
        halt_now_cause = CAUSE_SELFLOOP;
      end else if (bkpt_en && !skip_q && (core_pc == bkpt_addr)) begin
        halt_now       = 1'b1;
        halt_now_cause = CAUSE_BKPT;
      end
    end
  end

  assign core_en = active && !halt_now;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    v_d     = v_q;
    skip_d  = skip_q;
    if (!active) begin
      if (cmd_valid && (cmd_op == OP_RUN)) begin
        state_d = ST_RUN;
        skip_d  = 1'b1;
        v_d     = 1'b0;
      end else if (cmd_valid && (cmd_op == OP_STEP)) begin
        state_d = ST_STEP;
        cnt_d   = (cmd_arg == CNT_ZERO) ? CNT_ONE : cmd_arg;
        skip_d  = 1'b1;
        v_d     = 1'b0;
      end
    end else if (halt_now) begin
      state_d = ST_HALT;
      cause_d = halt_now_cause;
      done_d  = 1'b1;
    end else begin
      pc_d   = core_pc;
      v_d    = 1'b1;
      skip_d = 1'b0;
      if (state_q == ST_STEP) begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_HALT;
          cause_d = CAUSE_STEP_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HALT;
      cause_q <= CAUSE_NONE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      pc_q    <= '0;
      v_q     <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      v_q     <= v_d;
      skip_q  <= skip_d;
    end
  end

`ifdef POLIRISCV_RUNCTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (core_en) begin
      instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: doc/poliriscv_run_ctrl.md
Name: poliriscv_run_ctrl

Overview:
- Run-control sequencer for the single-cycle core `poliriscv_sc`.
- Gates the core through a clock-enable, so the core advances PC, register file and data memory only when `core_en` = 1.
- Accepts run, step and halt commands; halts on a PC breakpoint or on a self-loop (PC unchanged across an executed instruction).
- Replaces bench-side "PC stopped changing → finish" polling with a hardware halt and a cause code.

Parameters:
- PCW, 32, width of the core PC and of the breakpoint address.
- STEPW, 16, width of the step-count argument and of the step counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  constant 1; every valid command is accepted the cycle it is presented.
- cmd_op  in  2  command: 00 HALT, 01 RUN, 10 STEP, 11 reserved (accepted and ignored).
- cmd_arg  in  STEPW  instruction count for STEP; 0 is treated as 1.
- bkpt_en  in  1  breakpoint compare enable.
- bkpt_addr  in  PCW  breakpoint PC.
- core_pc  in  PCW  current PC of the core; the address of the instruction executing this cycle.
- core_en  out  1  core clock-enable; combinational.
- state  out  2  state register: 0 HALT, 1 RUN, 2 STEP.
- halt_cause  out  3  cause code: 0 NONE, 1 CMD, 2 STEP_DONE, 3 BKPT, 4 SELFLOOP.
- done  out  1  one-cycle pulse, registered, asserted in the cycle after the RUN/STEP→HALT transition.

Behaviour:
- Reset (async):
  - state=HALT, halt_cause=NONE, done=0, step counter=0, pc_q=0, v_q=0, skip_q=0.
  - core_en=0 while rst=1 and afterwards until a command is accepted.
- Command acceptance: a command is accepted on any rising edge with cmd_valid=1.
- In HALT:
  - RUN → RUN.
  - STEP → STEP, counter loaded with max(cmd_arg, 1).
  - HALT → no change.
  - On entry to RUN/STEP: skip_q=1, v_q=0, halt_cause unchanged until the next halt.
- In RUN/STEP: HALT command → HALT, cause CMD. RUN and STEP commands are ignored.
- halt_now (combinational, evaluated only in RUN/STEP), priority order:
  1. HALT command accepted this cycle → CMD.
  2. v_q && core_pc==pc_q → SELFLOOP.
  3. bkpt_en && !skip_q && core_pc==bkpt_addr → BKPT.
- core_en = (state==RUN || state==STEP) && !halt_now.
  - A halted-on instruction is not executed.
  - A breakpoint instruction is executed on resume, because skip_q suppresses the compare for the first cycle.
- On each edge with core_en=1:
  - pc_q←core_pc, v_q←1, skip_q←0.
  - In STEP, counter decrements; if the counter was 1 → HALT, cause STEP_DONE.
- Any halt_now in RUN/STEP → HALT with the cause above at that edge; done=1 in the following cycle only.
- Latency: a command accepted at edge k gives core_en=1 in cycle k+1.
  - STEP N yields exactly N cycles with core_en=1, absent other halts.
- SELFLOOP halts after the looping instruction has executed once, e.g. `jal x0,0`.
- Counter width: no wrap; STEP with cmd_arg=2^STEPW−1 runs that many instructions.
- rst asserted mid-run: immediate HALT, all state cleared; the core is reset in parallel by the same rst.

Optional Feature:
- Macro: POLIRISCV_RUNCTRL_PERF_EN.
- Defined:
  - Adds output `instret` (32 bits), incremented on every edge with core_en=1.
  - Wraps at 2^32; cleared only by rst; not cleared by commands.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, no commands, 20 cycles → state=0, core_en=0, halt_cause=0, done=0 throughout.
- STEP cmd_arg=3 at PC 0x00 with sequential code → exactly 3 core_en cycles (PC 0x00,0x04,0x08), state=HALT, halt_cause=2, one done pulse, core_pc=0x0C.
- bkpt_en=1, bkpt_addr=0x10, RUN → halts with core_pc=0x10 and the instruction not executed, halt_cause=3; RUN again → 0x10 executes, next PC 0x14, no immediate re-halt.
- Program ending in `jal x0,0` at 0x20, RUN → one core_en cycle at 0x20, then HALT with halt_cause=4 and done pulse; with PERF_EN, instret equals the executed instruction count.
- RUN, then HALT command at cycle 5 → core_en=0 that same cycle, halt_cause=1; HALT command while already HALT → no done pulse.
- STEP cmd_arg=0 → exactly 1 instruction executed; rst pulsed mid-RUN → state=0, core_en=0 immediately (async), halt_cause=0.
